// File: rtl/register_file_banked.sv
// rtl/register_file_banked.sv - parametrised two-read/one-write register file with a single-level shadow bank
module register_file_banked #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  input  logic              save,
  input  logic              restore,
  output logic              shadow_valid,
  output logic              restore_err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] main_q   [DEPTH];
  logic [DATA_W-1:0] shadow_q [DEPTH];
  logic              shadow_valid_q;
  logic              restore_err_q;

  logic do_swap;
  logic do_save;
  logic do_restore;
  logic restore_miss;

  // Decode the bank operation; save+restore on an empty shadow degrades to a plain save
  always_comb begin
    do_swap      = save && restore && shadow_valid_q;
    do_save      = save && !do_swap;
    do_restore   = restore && !save && shadow_valid_q;
    restore_miss = restore && !save && !shadow_valid_q;
  end

  // Bank copy/swap first, then the concurrent write lands on top of the new main contents
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        main_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
      shadow_valid_q <= 1'b0;
      restore_err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_save || do_swap)
          shadow_q[i] <= main_q[i];
        if (do_restore || do_swap)
          main_q[i] <= shadow_q[i];
        if (reg_write && write_reg == ADDR_W'(i))
          main_q[i] <= write_data;
        // register 0 is pinned so neither writes nor restores can disturb it
        if (ZERO_REG != 0 && i == 0)
          main_q[i] <= '0;
      end
      if (do_save || do_swap)
        shadow_valid_q <= 1'b1;
      else if (do_restore)
        shadow_valid_q <= 1'b0;
      restore_err_q <= restore_miss;
    end
  end

  // Combinational reads; bypass forwards only the current write, zero register masks last
  always_comb begin
    read_data1 = main_q[read_reg1];
    read_data2 = main_q[read_reg2];
    if (BYPASS != 0 && reg_write && write_reg == read_reg1)
      read_data1 = write_data;
    if (BYPASS != 0 && reg_write && write_reg == read_reg2)
      read_data2 = write_data;
    if (ZERO_REG != 0 && read_reg1 == '0)
      read_data1 = '0;
    if (ZERO_REG != 0 && read_reg2 == '0)
      read_data2 = '0;
  end

  assign shadow_valid = shadow_valid_q;
  assign restore_err  = restore_err_q;

endmodule

// File: tb/tb_register_file_banked.sv
// tb/tb_register_file_banked.sv - self-checking bench for register_file_banked
module tb_register_file_banked;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rd1, rd2, wr;
  logic [7:0] wd;
  logic       we, save, restore;

  logic [7:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic       a_sv, a_err, b_sv, b_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  register_file_banked #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .read_reg1(rd1), .read_reg2(rd2),
    .read_data1(a_rd1), .read_data2(a_rd2), .write_reg(wr), .write_data(wd),
    .reg_write(we), .save(save), .restore(restore),
    .shadow_valid(a_sv), .restore_err(a_err));

  register_file_banked #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .read_reg1(rd1), .read_reg2(rd2),
    .read_data1(b_rd1), .read_data2(b_rd2), .write_reg(wr), .write_data(wd),
    .reg_write(we), .save(save), .restore(restore),
    .shadow_valid(b_sv), .restore_err(b_err));

  // Reference model: index 0 mirrors dut_a, index 1 mirrors dut_b
  logic [7:0] m_main   [2][8];
  logic [7:0] m_shadow [2][8];
  bit         m_sv  [2];
  bit         m_err [2];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input int k, input logic [2:0] addr);
    if (k == 1 && addr == 3'd0) return 8'h00;
    if (k == 0 && we && wr == addr) return wd;
    return m_main[k][addr];
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      logic [7:0] pre [8];
      bit old_sv;
      old_sv = m_sv[k];
      if (!rst) begin
        for (int i = 0; i < 8; i++) begin
          m_main[k][i] = 8'h00;
          m_shadow[k][i] = 8'h00;
        end
        m_sv[k] = 0;
        m_err[k] = 0;
      end else begin
        for (int i = 0; i < 8; i++) pre[i] = m_main[k][i];
        m_err[k] = restore && !save && !old_sv;
        if (save && restore && old_sv) begin
          for (int i = 0; i < 8; i++) begin
            m_main[k][i] = m_shadow[k][i];
            m_shadow[k][i] = pre[i];
          end
        end else if (save) begin
          for (int i = 0; i < 8; i++) m_shadow[k][i] = pre[i];
          m_sv[k] = 1;
        end else if (restore && old_sv) begin
          for (int i = 0; i < 8; i++) m_main[k][i] = m_shadow[k][i];
          m_sv[k] = 0;
        end
        if (we) m_main[k][wr] = wd;
        if (k == 1) m_main[1][0] = 8'h00;
      end
    end
  endtask

  task automatic check_model(input bit check_a);
    if (check_a) begin
      chk("a_rd1_model", a_rd1, model_read(0, rd1));
      chk("a_rd2_model", a_rd2, model_read(0, rd2));
      chk("a_sv_model", {7'd0, a_sv}, {7'd0, m_sv[0]});
      chk("a_err_model", {7'd0, a_err}, {7'd0, m_err[0]});
    end
    chk("b_rd1_model", b_rd1, model_read(1, rd1));
    chk("b_rd2_model", b_rd2, model_read(1, rd2));
    chk("b_sv_model", {7'd0, b_sv}, {7'd0, m_sv[1]});
    chk("b_err_model", {7'd0, b_err}, {7'd0, m_err[1]});
  endtask

  task automatic drive(input bit r, input bit w, input logic [2:0] wa, input logic [7:0] wdat,
                       input logic [2:0] r1, input logic [2:0] r2, input bit s, input bit rs);
    rst = r; we = w; wr = wa; wd = wdat; rd1 = r1; rd2 = r2; save = s; restore = rs;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    bit         r, w, s, rs;
    logic [2:0] wa, r1, r2;
    logic [7:0] wdat, e1, e2;
    bit         esv, eerr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit r, input bit w, input logic [2:0] wa, input logic [7:0] wdat,
                              input logic [2:0] r1, input logic [2:0] r2, input bit s, input bit rs,
                              input logic [7:0] e1, input logic [7:0] e2, input bit esv, input bit eerr);
    vec_t v;
    v.r = r; v.w = w; v.wa = wa; v.wdat = wdat; v.r1 = r1; v.r2 = r2; v.s = s; v.rs = rs;
    v.e1 = e1; v.e2 = e2; v.esv = esv; v.eerr = eerr;
    return v;
  endfunction

  initial begin
    // rst w wa wdat r1 r2 s rs | pre-edge expected for dut_a: rd1 rd2 sv err
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 7, 0, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(1, 1, 1, 8'hAA, 1, 2, 0, 0, 8'hAA, 8'h00, 0, 0));
    tbl.push_back(mk(1, 1, 2, 8'hBB, 1, 2, 0, 0, 8'hAA, 8'hBB, 0, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 2, 0, 0, 8'hAA, 8'hBB, 0, 0));
    tbl.push_back(mk(1, 1, 3, 8'hCC, 3, 3, 0, 0, 8'hCC, 8'hCC, 0, 0));
    tbl.push_back(mk(1, 1, 1, 8'h11, 1, 3, 1, 0, 8'h11, 8'hCC, 0, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 2, 0, 0, 8'h11, 8'hBB, 1, 0));
    tbl.push_back(mk(1, 1, 2, 8'h22, 2, 1, 0, 0, 8'h22, 8'h11, 1, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 2, 0, 1, 8'h11, 8'h22, 1, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 2, 0, 0, 8'hAA, 8'hBB, 0, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 3, 0, 1, 8'hAA, 8'hCC, 0, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 2, 0, 0, 8'hAA, 8'hBB, 0, 1));
    tbl.push_back(mk(1, 1, 1, 8'h11, 1, 3, 1, 0, 8'h11, 8'hCC, 0, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 2, 1, 1, 8'h11, 8'hBB, 1, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 2, 0, 0, 8'hAA, 8'hBB, 1, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 3, 1, 1, 8'hAA, 8'hCC, 1, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 2, 0, 0, 8'h11, 8'hBB, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 2, 1, 0, 8'h11, 8'hBB, 1, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 2, 0, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 2, 0, 1, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 2, 0, 0, 8'h00, 8'h00, 0, 1));
    tbl.push_back(mk(1, 1, 4, 8'h44, 4, 0, 1, 1, 8'h44, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 4, 0, 0, 0, 8'h44, 8'h00, 1, 0));

    drive(0, 0, 0, 8'h00, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      m_sv[k] = 0;
      m_err[k] = 0;
    end
    finish_cycle();
    finish_cycle();

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].w, tbl[i].wa, tbl[i].wdat, tbl[i].r1, tbl[i].r2, tbl[i].s, tbl[i].rs);
      @(negedge clk);
      chk($sformatf("tbl%0d_rd1", i), a_rd1, tbl[i].e1);
      chk($sformatf("tbl%0d_rd2", i), a_rd2, tbl[i].e2);
      chk($sformatf("tbl%0d_sv", i), {7'd0, a_sv}, {7'd0, tbl[i].esv});
      chk($sformatf("tbl%0d_err", i), {7'd0, a_err}, {7'd0, tbl[i].eerr});
      check_model(1'b0);
      finish_cycle();
    end

    // Hand sequence: bypass-off visibility and zero register on dut_b
    drive(0, 0, 0, 8'h00, 0, 0, 0, 0);
    finish_cycle();
    drive(1, 1, 3, 8'hCC, 3, 3, 0, 0);
    @(negedge clk);
    chk("nobyp_pre_b", b_rd1, 8'h00);
    chk("byp_pre_a", a_rd1, 8'hCC);
    finish_cycle();
    drive(1, 0, 0, 8'h00, 3, 3, 0, 0);
    @(negedge clk);
    chk("nobyp_post_b", b_rd1, 8'hCC);
    finish_cycle();
    drive(1, 1, 0, 8'hFF, 0, 0, 0, 0);
    @(negedge clk);
    chk("zero_byp_b", b_rd1, 8'h00);
    chk("r0_byp_a", a_rd1, 8'hFF);
    finish_cycle();
    drive(1, 0, 0, 8'h00, 0, 0, 1, 0);
    @(negedge clk);
    chk("zero_post_b", b_rd1, 8'h00);
    chk("r0_post_a", a_rd1, 8'hFF);
    finish_cycle();
    drive(1, 1, 0, 8'h77, 0, 3, 0, 1);
    @(negedge clk);
    finish_cycle();
    drive(1, 0, 0, 8'h00, 0, 3, 0, 0);
    @(negedge clk);
    chk("zero_restore_b", b_rd1, 8'h00);
    chk("restore_a_r0", a_rd1, 8'h77);
    chk("restore_b_r3", b_rd2, 8'hCC);
    finish_cycle();

    // Randomised phase against the reference model
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 31) != 0), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
            8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      @(negedge clk);
      check_model(1'b1);
      finish_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
